// File: rtl/sram_like_mem_slave_if.sv
// Sram-like bus between a cache (master) and its backing memory (slave).
interface sram_like_mem_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_mem_slave.sv
// Word-addressed backing memory on the sram-like bus with programmable
// address-accept and data-return latency; one transaction at a time.
module sram_like_mem_slave #(
  parameter int MEM_INDEX_WIDTH = 10,
  parameter int ADDR_LAT        = 0,
  parameter int DATA_LAT        = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  sram_like_mem_slave_if.slave   bus
);

  localparam int unsigned DEPTH   = 1 << MEM_INDEX_WIDTH;
  localparam logic [3:0]  ALAT    = 4'(ADDR_LAT);
  localparam logic [3:0]  DLAT_M1 = 4'(DATA_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA_WAIT,
    RESP
  } state_t;

  state_t                     r_state, w_next;
  logic [3:0]                 r_acnt, w_acnt_nxt;
  logic [3:0]                 r_dcnt, w_dcnt_nxt;
  logic                       r_wr;
  logic [MEM_INDEX_WIDTH-1:0] r_idx;
  logic                       r_data_ok;
  logic [31:0]                r_rdata;
  logic [31:0]                r_mem [DEPTH];

  logic                       w_addr_ok;
  logic                       w_hs;
  logic [3:0]                 w_be;
  logic [MEM_INDEX_WIDTH-1:0] w_in_idx;
  logic [MEM_INDEX_WIDTH-1:0] w_rd_idx;
  logic                       w_rd_wr;
  logic                       w_unused_addr;

  assign w_in_idx      = bus.addr[MEM_INDEX_WIDTH+1:2];
  assign w_unused_addr = ^bus.addr[31:MEM_INDEX_WIDTH+2];

  always_comb begin
    w_be = 4'b1111;
    case (bus.size)
      2'b00:   w_be = 4'b0001 << bus.addr[1:0];
      2'b01:   w_be = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_acnt_nxt = '0;
    w_dcnt_nxt = r_dcnt;
    w_addr_ok  = 1'b0;
    w_hs       = 1'b0;
    case (r_state)
      IDLE: begin
        w_addr_ok = bus.req && (r_acnt == ALAT);
        w_hs      = w_addr_ok;
        if (w_hs) begin
          w_dcnt_nxt = 4'd1;
          w_next     = (DATA_LAT == 1) ? RESP : DATA_WAIT;
        end else if (bus.req) begin
          w_acnt_nxt = r_acnt + 4'd1;
        end
      end
      DATA_WAIT: begin
        w_dcnt_nxt = r_dcnt + 4'd1;
        if (r_dcnt == DLAT_M1) w_next = RESP;
      end
      RESP: begin
        w_dcnt_nxt = '0;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // With DATA_LAT == 1, RESP is entered at the handshake edge itself, so the
  // read index and direction come straight from the bus rather than the latch.
  assign w_rd_idx = (r_state == IDLE) ? w_in_idx : r_idx;
  assign w_rd_wr  = (r_state == IDLE) ? bus.wr   : r_wr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_acnt    <= '0;
      r_dcnt    <= '0;
      r_wr      <= 1'b0;
      r_idx     <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_acnt    <= w_acnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_data_ok <= (w_next == RESP);
      r_rdata   <= ((w_next == RESP) && !w_rd_wr) ? r_mem[w_rd_idx] : '0;
      if (w_hs) begin
        r_wr  <= bus.wr;
        r_idx <= w_in_idx;
      end
    end
  end

  // Memory has no reset so contents survive resetn.
  always_ff @(posedge clk) begin
    if (w_hs && bus.wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_in_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.addr_ok = w_addr_ok;
  assign bus.data_ok = r_data_ok;
  assign bus.rdata   = r_rdata;

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed bench for sram_like_mem_slave: two instances with different
// latencies, expected read data queued at issue and checked at data_ok.
module tb_sram_like_mem_slave;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_like_mem_slave_if bus0 ();
  sram_like_mem_slave_if bus1 ();

  sram_like_mem_slave #(.MEM_INDEX_WIDTH(10), .ADDR_LAT(0), .DATA_LAT(1)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0)
  );
  sram_like_mem_slave #(.MEM_INDEX_WIDTH(10), .ADDR_LAT(3), .DATA_LAT(4)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", tag);
  endtask

  task automatic drv(input int sel, input logic r, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      bus0.req = r; bus0.wr = w; bus0.size = sz; bus0.addr = a; bus0.wdata = wd;
    end else begin
      bus1.req = r; bus1.wr = w; bus1.size = sz; bus1.addr = a; bus1.wdata = wd;
    end
  endtask

  function automatic logic aok(input int sel);
    return (sel == 0) ? bus0.addr_ok : bus1.addr_ok;
  endfunction
  function automatic logic dok(input int sel);
    return (sel == 0) ? bus0.data_ok : bus1.data_ok;
  endfunction
  function automatic logic [31:0] rd(input int sel);
    return (sel == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge leaving RESP.
  task automatic xact(input int sel, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp,
                      input int alat, input int dlat, input bit hold);
    int n;
    int d;
    logic [31:0] e;
    sb_q.push_back(w ? 32'h0 : exp);
    drv(sel, 1'b1, w, sz, a, wd);
    n = 0;
    forever begin
      @(negedge clk);
      chk("dok_idle", 32'(dok(sel)), 32'h0);
      if (aok(sel)) break;
      n++;
      if (n > 40) begin
        timeout("addr_ok");
        e = sb_q.pop_front();
        drv(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        return;
      end
      @(posedge clk); #1;
    end
    chk("addr_lat", 32'(n), 32'(alat));
    @(posedge clk); #1;
    if (!hold) drv(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    d = 1;
    forever begin
      @(negedge clk);
      chk("aok_busy", 32'(aok(sel)), 32'h0);
      if (dok(sel)) break;
      d++;
      if (d > 40) begin
        timeout("data_ok");
        e = sb_q.pop_front();
        return;
      end
      @(posedge clk); #1;
    end
    chk("data_lat", 32'(d), 32'(dlat));
    e = sb_q.pop_front();
    chk("rdata", rd(sel), e);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    drv(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_aok0", 32'(bus0.addr_ok), 32'h0);
    chk("rst_dok0", 32'(bus0.data_ok), 32'h0);
    chk("rst_rd0",  bus0.rdata, 32'h0);
    chk("rst_dok1", 32'(bus1.data_ok), 32'h0);
    chk("rst_rd1",  bus1.rdata, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // dut0: ADDR_LAT=0, DATA_LAT=1
    xact(0, 1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 1, 0);
    xact(0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 1, 0);
    // byte / halfword lane masking
    xact(0, 1'b1, 2'b10, 32'h0000_0200, 32'h1122_3344, 32'h0,         0, 1, 0);
    xact(0, 1'b1, 2'b00, 32'h0000_0201, 32'h0000_AA00, 32'h0,         0, 1, 0);
    xact(0, 1'b1, 2'b01, 32'h0000_0202, 32'hBBCC_0000, 32'h0,         0, 1, 0);
    xact(0, 1'b0, 2'b00, 32'h0000_0200, 32'h0,         32'hBBCC_AA44, 0, 1, 0);
    // aliasing above the index bits
    xact(0, 1'b1, 2'b10, 32'h0000_0010, 32'h0000_0005, 32'h0,         0, 1, 0);
    xact(0, 1'b0, 2'b10, 32'h0000_1010, 32'h0,         32'h0000_0005, 0, 1, 0);
    // misaligned word and halfword
    xact(0, 1'b1, 2'b10, 32'h0000_0303, 32'hCAFE_F00D, 32'h0,         0, 1, 0);
    xact(0, 1'b0, 2'b10, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 0, 1, 0);
    xact(0, 1'b1, 2'b01, 32'h0000_0301, 32'h0000_1234, 32'h0,         0, 1, 0);
    xact(0, 1'b0, 2'b10, 32'h0000_0302, 32'h0,         32'hCAFE_1234, 0, 1, 0);
    // back-to-back with req held
    xact(0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 1, 1);
    xact(0, 1'b0, 2'b10, 32'h0000_0200, 32'h0,         32'hBBCC_AA44, 0, 1, 0);
    @(negedge clk);
    chk("dok_after0", 32'(bus0.data_ok), 32'h0);
    @(posedge clk); #1;

    // dut1: ADDR_LAT=3, DATA_LAT=4
    xact(1, 1'b1, 2'b10, 32'h0000_0040, 32'h0BAD_CAFE, 32'h0,         3, 4, 0);
    xact(1, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         32'h0BAD_CAFE, 3, 4, 0);
    xact(1, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         32'h0BAD_CAFE, 3, 4, 1);
    xact(1, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         32'h0BAD_CAFE, 3, 4, 0);

    // req withdrawn before addr_ok: acnt must restart
    drv(1, 1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("early_aok", 32'(bus1.addr_ok), 32'h0);
      @(posedge clk); #1;
    end
    drv(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(posedge clk); #1;
    xact(1, 1'b0, 2'b10, 32'h0000_0040, 32'h0,         32'h0BAD_CAFE, 3, 4, 0);

    // reset during DATA_WAIT after a write handshake
    drv(1, 1'b1, 1'b1, 2'b10, 32'h0000_0080, 32'h600D_F00D);
    n = 0;
    forever begin
      @(negedge clk);
      if (bus1.addr_ok) break;
      n++;
      if (n > 40) begin
        timeout("rst_hs");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drv(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_dok", 32'(bus1.data_ok), 32'h0);
    chk("mid_rst_aok", 32'(bus1.addr_ok), 32'h0);
    chk("mid_rst_rd",  bus1.rdata, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_dok", 32'(bus1.data_ok), 32'h0);
      @(posedge clk); #1;
    end
    xact(1, 1'b0, 2'b10, 32'h0000_0080, 32'h0,         32'h600D_F00D, 3, 4, 0);
    xact(0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 1, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_mem_slave.md
Name: sram_like_mem_slave

Overview:
Responder end of the sram-like bus that the data cache drives on its memory side (req/wr/size/addr/wdata out; rdata/addr_ok/data_ok in). It is a word-addressed backing memory with programmable address-accept and data-return latency. It stands in for the AXI bridge plus memory in cache-level benches and in the standalone SoC.
It services one transaction at a time, so the cache's miss and write-through paths are exercised with real stall timing.

Parameters:
MEM_INDEX_WIDTH, 10, log2 of memory depth in 32-bit words; addr[MEM_INDEX_WIDTH+1:2] selects the word, upper address bits are ignored (aliasing).
ADDR_LAT, 0, number of cycles req must be held high before addr_ok asserts (0..15; 0 = addr_ok in the first req cycle).
DATA_LAT, 2, cycles from the address-handshake edge to the data_ok cycle (1..15).

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req  in  1  request valid from initiator
wr  in  1  1 = write, 0 = read
size  in  2  00 byte, 01 halfword, 10/11 word
addr  in  32  byte address
wdata  in  32  write data, byte lanes aligned to addr[1:0]
rdata  out  32  read data, valid only while data_ok = 1
addr_ok  out  1  address accepted (handshake = req & addr_ok in the same cycle)
data_ok  out  1  transaction complete, one-cycle pulse

Behaviour:
- Reset (resetn = 0, async): state IDLE, addr counter and data counter = 0, data_ok = 0, rdata = 0, addr_ok = 0. Memory contents are not reset and are preserved across reset.
- States:
  - IDLE: waiting for a request.
  - DATA_WAIT: a transaction is accepted and its latency is counting.
  - RESP: data_ok = 1 for exactly one cycle.
- IDLE:
  - acnt increments each cycle that req = 1 and the handshake has not occurred.
  - acnt clears to 0 when req = 0.
  - addr_ok = req & (acnt == ADDR_LAT), combinational from req.
  - On handshake: latch wr, size, addr, wdata; acnt := 0; dcnt := 1.
  - On handshake: next state is RESP if DATA_LAT == 1, otherwise DATA_WAIT.
- DATA_WAIT:
  - dcnt increments each cycle.
  - When dcnt == DATA_LAT-1, next state is RESP.
  - addr_ok = 0; req is ignored.
- RESP:
  - data_ok = 1 (registered).
  - rdata = latched-word read value (registered); 0 for writes.
  - addr_ok = 0.
  - Next state is IDLE unconditionally.
  - A req held across RESP is serviced starting in the following IDLE cycle; acnt restarts at 0.
- data_ok falls exactly DATA_LAT cycles after the handshake edge, i.e. data_ok is high in the DATA_LAT-th cycle after the handshake cycle. Max one outstanding transaction.
- Write commit: at the handshake clock edge, using byte mask from size/addr[1:0]:
  - byte: 0001 / 0010 / 0100 / 1000 for addr[1:0] = 0 / 1 / 2 / 3.
  - halfword: 0011 if addr[1] = 0, 1100 if addr[1] = 1.
  - word: 1111.
  - Only masked bytes change; the others are unchanged.
- Read: the full 32-bit word at the latched index is sampled at the edge entering RESP. size does not mask read data; the initiator extracts lanes.
- Read after write to the same word: the read returns the written data, because the write commits at handshake.
- Misaligned halfword/word addresses: addr[1:0] is ignored for word; addr[0] is ignored for halfword. No error signalling.
- Reset mid-transaction: the transaction is dropped and no data_ok is issued. A write whose handshake edge already occurred stays committed.
- req dropped before addr_ok (protocol violation): no transaction occurs; acnt returns to 0.
- acnt and dcnt are 4 bits wide. Parameter values outside their ranges are illegal, and implementations may assert on them.

Test Plan:
- ADDR_LAT=0, DATA_LAT=1: word write 0xDEADBEEF to 0x100, then read 0x100 -> addr_ok in the first req cycle of each transaction; data_ok 1 cycle after each handshake; read rdata = 0xDEADBEEF.
- ADDR_LAT=3, DATA_LAT=4: read held with req high -> addr_ok in the 4th req cycle; data_ok exactly 4 cycles after the handshake; addr_ok = 0 throughout DATA_WAIT/RESP.
- Byte/half masking: word 0x11223344 to 0x200, then sb 0xAA at 0x201, then sh 0xBBCC at 0x202 (wdata lane-aligned) -> read 0x200 returns 0xBBCCAA44.
- Aliasing with MEM_INDEX_WIDTH=10: write 0x5 at 0x0000_0010, read 0x0000_1010 -> rdata 0x5.
- Back-to-back: req held continuously for two reads -> second handshake no earlier than the cycle after RESP; data_ok pulses exactly 1 cycle each; never two transactions in flight.
- Reset mid-DATA_WAIT after a write handshake: resetn low 1 cycle -> no data_ok pulse, state IDLE, outputs 0; a later read returns the written data.
